// File: rtl/ldst_access_ctrl_pkg.sv
// ldst_access_ctrl_pkg: shared FSM states, access size codes and AFE codes for the load/store controller
package ldst_access_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_REQ   = 2'b01,
        ST_WAIT  = 2'b10,
        ST_DRAIN = 2'b11
    } ldst_state_e;

    localparam logic [1:0] LDST_SIZE_BYTE = 2'b00;
    localparam logic [1:0] LDST_SIZE_HALF = 2'b01;
    localparam logic [1:0] LDST_SIZE_WORD = 2'b10;

    localparam logic [3:0] AFE_LDST_NONE      = 4'h0;
    localparam logic [3:0] AFE_LDST_SEXT8_32  = 4'h1;
    localparam logic [3:0] AFE_LDST_SEXT16_32 = 4'h2;

endpackage

// File: rtl/ldst_access_ctrl_lane_align.sv
// ldst_lane_align: big-endian lane mapping for stores, lane extraction for loads, AFE code selection
// Ports: i_size/i_off/i_load/i_signed describe the access; i_wdata right-aligned store data;
//        i_rword returned memory word; o_mask byte enables (bit 3 = [31:24]); o_wdata replicated
//        store data; o_rdata zero-extended load data; o_afe AFE code; o_misalign alignment fault.
// Config: MIST_LDST_ALIGN_CHECK_EN enables misalignment detection, otherwise o_misalign is 0.
module ldst_lane_align
    import ldst_access_ctrl_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_off,
    input  logic        i_load,
    input  logic        i_signed,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_mask,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata,
    output logic [3:0]  o_afe,
    output logic        o_misalign
);
    logic [31:0] w_shift;
    logic        w_byte;
    logic        w_half;

    assign w_byte  = i_size == LDST_SIZE_BYTE;
    assign w_half  = i_size == LDST_SIZE_HALF;
    // offset k sits (3-k) bytes above bit 0, and 3-k == ~k for a 2-bit k
    assign w_shift = i_rword >> {~i_off, 3'b000};

    always_comb begin
        o_mask  = w_byte ? 4'b1000 >> i_off : w_half ? (i_off[1] ? 4'b0011 : 4'b1100) : 4'b1111;
        o_wdata = w_byte ? {4{i_wdata[7:0]}} : w_half ? {2{i_wdata[15:0]}} : i_wdata;
        o_rdata = w_byte ? {24'h0, w_shift[7:0]} :
                  w_half ? {16'h0, (i_off[1] ? i_rword[15:0] : i_rword[31:16])} : i_rword;
        o_afe   = (i_load && i_signed && w_byte) ? AFE_LDST_SEXT8_32 :
                  (i_load && i_signed && w_half) ? AFE_LDST_SEXT16_32 : AFE_LDST_NONE;
    end

`ifdef MIST_LDST_ALIGN_CHECK_EN
    assign o_misalign = (w_half && i_off[0]) || (i_size[1] && i_off != 2'b00);
`else
    assign o_misalign = 1'b0;
`endif

endmodule

// File: rtl/ldst_access_ctrl.sv
// ldst_access_ctrl: one-at-a-time load/store controller driving the data-memory handshake
// Ports: i_clk, i_rst_n (async, active-low), i_flush; execute side i_exe_* / o_exe_busy;
//        memory side o_data_req/rw/mask/addr/data, i_data_busy, i_data_valid, i_data_data;
//        completion side o_ldst_valid/data/afe_code/fault.
// Config: MIST_LDST_ALIGN_CHECK_EN turns misaligned halfword/word accesses into faults.
module ldst_access_ctrl
    import ldst_access_ctrl_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_flush,
    input  logic        i_exe_valid,
    output logic        o_exe_busy,
    input  logic        i_exe_load,
    input  logic [1:0]  i_exe_size,
    input  logic        i_exe_signed,
    input  logic [31:0] i_exe_addr,
    input  logic [31:0] i_exe_data,
    output logic        o_data_req,
    input  logic        i_data_busy,
    output logic        o_data_rw,
    output logic [3:0]  o_data_mask,
    output logic [31:0] o_data_addr,
    output logic [31:0] o_data_data,
    input  logic        i_data_valid,
    input  logic [31:0] i_data_data,
    output logic        o_ldst_valid,
    output logic [31:0] o_ldst_data,
    output logic [3:0]  o_ldst_afe_code,
    output logic        o_ldst_fault
);
    ldst_state_e r_state;
    logic        r_load;
    logic [1:0]  r_size;
    logic [1:0]  r_off;
    logic        r_signed;
    logic        r_mis;
    logic        r_req;
    logic        r_rw;
    logic [3:0]  r_mask;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_valid;
    logic [31:0] r_ldata;
    logic [3:0]  r_afe;
    logic        r_fault;

    logic        w_idle;
    logic [1:0]  w_size;
    logic [1:0]  w_off;
    logic        w_load;
    logic        w_signed;
    logic [3:0]  w_mask;
    logic [31:0] w_wdata;
    logic [31:0] w_rdata;
    logic [3:0]  w_afe;
    logic        w_mis;

    // in IDLE the aligner sees the offered operation, afterwards the captured one
    assign w_idle   = r_state == ST_IDLE;
    assign w_size   = w_idle ? i_exe_size   : r_size;
    assign w_off    = w_idle ? i_exe_addr[1:0] : r_off;
    assign w_load   = w_idle ? i_exe_load   : r_load;
    assign w_signed = w_idle ? i_exe_signed : r_signed;

    ldst_lane_align u_align (
        .i_size     (w_size),
        .i_off      (w_off),
        .i_load     (w_load),
        .i_signed   (w_signed),
        .i_wdata    (i_exe_data),
        .i_rword    (i_data_data),
        .o_mask     (w_mask),
        .o_wdata    (w_wdata),
        .o_rdata    (w_rdata),
        .o_afe      (w_afe),
        .o_misalign (w_mis)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_IDLE;
            r_load   <= 1'b0;
            r_size   <= LDST_SIZE_BYTE;
            r_off    <= 2'b00;
            r_signed <= 1'b0;
            r_mis    <= 1'b0;
            r_req    <= 1'b0;
            r_rw     <= 1'b0;
            r_mask   <= 4'h0;
            r_addr   <= 32'h0;
            r_wdata  <= 32'h0;
            r_valid  <= 1'b0;
            r_ldata  <= 32'h0;
            r_afe    <= AFE_LDST_NONE;
            r_fault  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_fault <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!i_flush && i_exe_valid) begin
                        r_load   <= i_exe_load;
                        r_size   <= i_exe_size;
                        r_off    <= i_exe_addr[1:0];
                        r_signed <= i_exe_signed;
                        r_mis    <= w_mis;
                        r_req    <= !w_mis;
                        r_rw     <= !i_exe_load;
                        // reads carry no byte enables; the lane is picked on return
                        r_mask   <= i_exe_load ? 4'h0 : w_mask;
                        r_addr   <= {i_exe_addr[31:2], 2'b00};
                        r_wdata  <= w_wdata;
                        r_state  <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (i_flush) begin
                        r_req   <= 1'b0;
                        r_mis   <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (r_mis) begin
                        r_mis   <= 1'b0;
                        r_valid <= 1'b1;
                        r_fault <= 1'b1;
                        r_ldata <= 32'h0;
                        r_afe   <= w_afe;
                        r_state <= ST_IDLE;
                    end else if (!i_data_busy) begin
                        r_req <= 1'b0;
                        if (r_load) begin
                            r_state <= ST_WAIT;
                        end else begin
                            r_valid <= 1'b1;
                            r_ldata <= 32'h0;
                            r_afe   <= w_afe;
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_WAIT: begin
                    if (i_flush) begin
                        r_state <= i_data_valid ? ST_IDLE : ST_DRAIN;
                    end else if (i_data_valid) begin
                        r_valid <= 1'b1;
                        r_ldata <= w_rdata;
                        r_afe   <= w_afe;
                        r_state <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (i_data_valid) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_exe_busy      = !w_idle;
    assign o_data_req      = r_req;
    assign o_data_rw       = r_rw;
    assign o_data_mask     = r_mask;
    assign o_data_addr     = r_addr;
    assign o_data_data     = r_wdata;
    assign o_ldst_valid    = r_valid;
    assign o_ldst_data     = r_ldata;
    assign o_ldst_afe_code = r_afe;
    assign o_ldst_fault    = r_fault;

endmodule

// File: tb/tb_ldst_access_ctrl.sv
// tb_ldst_access_ctrl: directed self-checking bench for ldst_access_ctrl
module tb_ldst_access_ctrl;
    import ldst_access_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        exe_valid = 1'b0;
    logic        exe_busy;
    logic        exe_load = 1'b0;
    logic [1:0]  exe_size = 2'b00;
    logic        exe_signed = 1'b0;
    logic [31:0] exe_addr = 32'h0;
    logic [31:0] exe_data = 32'h0;
    logic        data_req;
    logic        data_busy = 1'b0;
    logic        data_rw;
    logic [3:0]  data_mask;
    logic [31:0] data_addr;
    logic [31:0] data_data;
    logic        data_valid = 1'b0;
    logic [31:0] data_rdata = 32'h0;
    logic        ldst_valid;
    logic [31:0] ldst_data;
    logic [3:0]  ldst_afe;
    logic        ldst_fault;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ldst_access_ctrl dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_flush         (flush),
        .i_exe_valid     (exe_valid),
        .o_exe_busy      (exe_busy),
        .i_exe_load      (exe_load),
        .i_exe_size      (exe_size),
        .i_exe_signed    (exe_signed),
        .i_exe_addr      (exe_addr),
        .i_exe_data      (exe_data),
        .o_data_req      (data_req),
        .i_data_busy     (data_busy),
        .o_data_rw       (data_rw),
        .o_data_mask     (data_mask),
        .o_data_addr     (data_addr),
        .o_data_data     (data_data),
        .i_data_valid    (data_valid),
        .i_data_data     (data_rdata),
        .o_ldst_valid    (ldst_valid),
        .o_ldst_data     (ldst_data),
        .o_ldst_afe_code (ldst_afe),
        .o_ldst_fault    (ldst_fault)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // offered at a negedge, accepted on the next posedge, returns at the negedge of cycle 1
    task automatic issue(input logic ld, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] d);
        exe_valid  = 1'b1;
        exe_load   = ld;
        exe_size   = sz;
        exe_signed = sg;
        exe_addr   = a;
        exe_data   = d;
        cyc();
        exe_valid  = 1'b0;
    endtask

    task automatic load_word_resp(input logic [1:0] sz, input logic sg, input logic [31:0] a,
                                  input logic [31:0] word, input logic [31:0] exp,
                                  input logic [3:0] afe, input string tag);
        issue(1'b1, sz, sg, a, 32'h0);
        check({tag, "_req"}, {31'h0, data_req}, 32'h1);
        cyc();
        data_valid = 1'b1;
        data_rdata = word;
        cyc();
        data_valid = 1'b0;
        check({tag, "_valid"}, {31'h0, ldst_valid}, 32'h1);
        check({tag, "_data"}, ldst_data, exp);
        check({tag, "_afe"}, {28'h0, ldst_afe}, {28'h0, afe});
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy", {31'h0, exe_busy}, 32'h0);
        check("rst_req", {31'h0, data_req}, 32'h0);
        check("rst_mask", {28'h0, data_mask}, 32'h0);
        check("rst_addr", data_addr, 32'h0);
        check("rst_afe", {28'h0, ldst_afe}, {28'h0, AFE_LDST_NONE});
        rst_n = 1'b1;
        cyc();

        // signed byte load, offset 1
        issue(1'b1, LDST_SIZE_BYTE, 1'b1, 32'h0000_1001, 32'h0);
        check("bl_req", {31'h0, data_req}, 32'h1);
        check("bl_addr", data_addr, 32'h0000_1000);
        check("bl_mask", {28'h0, data_mask}, 32'h0);
        check("bl_rw", {31'h0, data_rw}, 32'h0);
        check("bl_busy", {31'h0, exe_busy}, 32'h1);
        cyc();
        check("bl_req_drop", {31'h0, data_req}, 32'h0);
        data_valid = 1'b1;
        data_rdata = 32'hAABB_CCDD;
        cyc();
        data_valid = 1'b0;
        check("bl_valid", {31'h0, ldst_valid}, 32'h1);
        check("bl_data", ldst_data, 32'h0000_00BB);
        check("bl_afe", {28'h0, ldst_afe}, {28'h0, AFE_LDST_SEXT8_32});
        cyc();
        check("bl_pulse", {31'h0, ldst_valid}, 32'h0);
        check("bl_hold", ldst_data, 32'h0000_00BB);

        // more lane extractions
        load_word_resp(LDST_SIZE_BYTE, 1'b0, 32'h0000_1003, 32'hAABB_CCDD, 32'h0000_00DD, AFE_LDST_NONE, "b3");
        load_word_resp(LDST_SIZE_HALF, 1'b1, 32'h0000_5002, 32'h8765_4321, 32'h0000_4321, AFE_LDST_SEXT16_32, "h2");
        load_word_resp(LDST_SIZE_HALF, 1'b0, 32'h0000_5000, 32'h8765_4321, 32'h0000_8765, AFE_LDST_NONE, "h0");

        // halfword store held off by busy for three cycles
        data_busy = 1'b1;
        issue(1'b0, LDST_SIZE_HALF, 1'b0, 32'h0000_2002, 32'hFFFF_1234);
        for (int i = 0; i < 3; i++) begin
            check("hs_req", {31'h0, data_req}, 32'h1);
            check("hs_mask", {28'h0, data_mask}, 32'h3);
            check("hs_data", data_data, 32'h1234_1234);
            check("hs_addr", data_addr, 32'h0000_2000);
            check("hs_rw", {31'h0, data_rw}, 32'h1);
            check("hs_novalid", {31'h0, ldst_valid}, 32'h0);
            cyc();
        end
        data_busy = 1'b0;
        check("hs_req_last", {31'h0, data_req}, 32'h1);
        cyc();
        check("hs_valid", {31'h0, ldst_valid}, 32'h1);
        check("hs_data_out", ldst_data, 32'h0);
        check("hs_req_drop", {31'h0, data_req}, 32'h0);
        check("hs_idle", {31'h0, exe_busy}, 32'h0);

        // byte store at offset 3
        issue(1'b0, LDST_SIZE_BYTE, 1'b0, 32'h0000_6003, 32'h0000_00A5);
        check("bs_mask", {28'h0, data_mask}, 32'h1);
        check("bs_data", data_data, 32'hA5A5_A5A5);
        cyc();
        check("bs_valid", {31'h0, ldst_valid}, 32'h1);

        // flush in WAIT, late response swallowed
        issue(1'b1, LDST_SIZE_WORD, 1'b0, 32'h0000_4000, 32'h0);
        cyc();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        check("fw_busy_drain", {31'h0, exe_busy}, 32'h1);
        cyc();
        data_valid = 1'b1;
        data_rdata = 32'h1111_1111;
        cyc();
        data_valid = 1'b0;
        check("fw_novalid", {31'h0, ldst_valid}, 32'h0);
        check("fw_idle", {31'h0, exe_busy}, 32'h0);
        check("fw_data_hold", ldst_data, 32'h0);
        load_word_resp(LDST_SIZE_WORD, 1'b0, 32'h0000_4004, 32'hCAFE_F00D, 32'hCAFE_F00D, AFE_LDST_NONE, "fw_next");

        // flush in REQ while busy
        data_busy = 1'b1;
        issue(1'b0, LDST_SIZE_WORD, 1'b0, 32'h0000_8000, 32'h0BAD_BEEF);
        check("fr_req", {31'h0, data_req}, 32'h1);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        data_busy = 1'b0;
        check("fr_req_drop", {31'h0, data_req}, 32'h0);
        check("fr_idle", {31'h0, exe_busy}, 32'h0);
        check("fr_novalid", {31'h0, ldst_valid}, 32'h0);

        // flush in IDLE blocks acceptance
        flush = 1'b1;
        issue(1'b1, LDST_SIZE_WORD, 1'b0, 32'h0000_9000, 32'h0);
        flush = 1'b0;
        check("fi_idle", {31'h0, exe_busy}, 32'h0);
        check("fi_noreq", {31'h0, data_req}, 32'h0);

        // misaligned word load
        issue(1'b1, LDST_SIZE_WORD, 1'b0, 32'h0000_3001, 32'h0);
`ifdef MIST_LDST_ALIGN_CHECK_EN
        check("mw_noreq", {31'h0, data_req}, 32'h0);
        check("mw_busy", {31'h0, exe_busy}, 32'h1);
        cyc();
        check("mw_valid", {31'h0, ldst_valid}, 32'h1);
        check("mw_fault", {31'h0, ldst_fault}, 32'h1);
        check("mw_data", ldst_data, 32'h0);
        cyc();
        check("mw_fault_pulse", {31'h0, ldst_fault}, 32'h0);
`else
        check("mw_req", {31'h0, data_req}, 32'h1);
        check("mw_addr", data_addr, 32'h0000_3000);
        cyc();
        data_valid = 1'b1;
        data_rdata = 32'h0102_0304;
        cyc();
        data_valid = 1'b0;
        check("mw_valid", {31'h0, ldst_valid}, 32'h1);
        check("mw_data", ldst_data, 32'h0102_0304);
        check("mw_nofault", {31'h0, ldst_fault}, 32'h0);
`endif

        // reset during WAIT
        issue(1'b1, LDST_SIZE_WORD, 1'b0, 32'h0000_7000, 32'h0);
        cyc();
        rst_n = 1'b0;
        #1;
        check("ar_busy", {31'h0, exe_busy}, 32'h0);
        check("ar_req", {31'h0, data_req}, 32'h0);
        check("ar_addr", data_addr, 32'h0);
        check("ar_ldata", ldst_data, 32'h0);
        check("ar_afe", {28'h0, ldst_afe}, {28'h0, AFE_LDST_NONE});
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        data_valid = 1'b1;
        data_rdata = 32'hDEAD_BEEF;
        cyc();
        data_valid = 1'b0;
        check("ar_ignore_valid", {31'h0, ldst_valid}, 32'h0);
        check("ar_ignore_data", ldst_data, 32'h0);
        check("ar_idle", {31'h0, exe_busy}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
